// File: rtl/fact_bus_pkg.sv
// Shared definitions for the factorial bus master: register offsets,
// FSM state encoding and the bus operation payload.
package fact_bus_pkg;

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 64;

  // Register offsets inside the factorial core window
  localparam logic [ADDR_W-1:0] OFF_OPSTART  = 16'h0000;
  localparam logic [ADDR_W-1:0] OFF_OPCLEAR  = 16'h0008;
  localparam logic [ADDR_W-1:0] OFF_OPDONE   = 16'h0010;
  localparam logic [ADDR_W-1:0] OFF_INTR_EN  = 16'h0018;
  localparam logic [ADDR_W-1:0] OFF_OPERAND  = 16'h0020;
  localparam logic [ADDR_W-1:0] OFF_RESULT_H = 16'h0028;
  localparam logic [ADDR_W-1:0] OFF_RESULT_L = 16'h0030;

  typedef enum logic [4:0] {
    ST_IDLE, ST_CLR1, ST_CLR0, ST_WR_OPND, ST_WR_IE, ST_WR_GO,
    ST_WAIT, ST_WAIT_CAP, ST_RD_H, ST_CAP_H, ST_RD_L, ST_CAP_L,
    ST_ST_L, ST_ST_H, ST_END1, ST_END0, ST_RESP
  } state_e;

  typedef struct packed {
    logic              req;
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] dout;
  } bus_op_t;

  // Build a requesting bus op
  function automatic bus_op_t mk_op(input logic wr, input logic [ADDR_W-1:0] addr,
                                    input logic [DATA_W-1:0] dout);
    bus_op_t op;
    op.req  = 1'b1;
    op.wr   = wr;
    op.addr = addr;
    op.dout = dout;
    return op;
  endfunction

endpackage

// File: rtl/fact_bus_if.sv
// Master-side memory bus: request/write/address/data out, grant/read data in.
interface fact_bus_if;
  import fact_bus_pkg::*;

  logic              m_req;
  logic              m_wr;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_dout;
  logic              m_grant;
  logic [DATA_W-1:0] m_din;

  modport master (output m_req, m_wr, m_addr, m_dout, input m_grant, m_din);
  modport slave  (input m_req, m_wr, m_addr, m_dout, output m_grant, m_din);

endinterface

// File: rtl/fact_bus_xfer.sv
// Single-transfer engine. Registers the op onto the bus and freezes it while
// a request is pending without grant; flags completion and read-data phase.
// Ports: clk, reset_n, op_i (next op), bus (master modport),
//        done_c (transfer completes this edge), rvalid_c/rdata_c (m_din valid).
module fact_bus_xfer
  import fact_bus_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  bus_op_t           op_i,
  fact_bus_if.master        bus,
  output logic              done_c,
  output logic              rvalid_c,
  output logic [DATA_W-1:0] rdata_c
);

  logic rd_pend_q;
  logic hold_c;

  assign hold_c   = bus.m_req & ~bus.m_grant;
  assign done_c   = bus.m_req & bus.m_grant;
  assign rvalid_c = rd_pend_q;
  assign rdata_c  = bus.m_din;

  // Bus outputs, held while stalled; read data arrives the cycle after completion
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.m_req  <= 1'b0;
      bus.m_wr   <= 1'b0;
      bus.m_addr <= '0;
      bus.m_dout <= '0;
      rd_pend_q  <= 1'b0;
    end else begin
      if (!hold_c) begin
        bus.m_req  <= op_i.req;
        bus.m_wr   <= op_i.wr;
        bus.m_addr <= op_i.addr;
        bus.m_dout <= op_i.dout;
      end
      rd_pend_q <= done_c & ~bus.m_wr;
    end
  end

endmodule

// File: rtl/fact_bus_master.sv
// Runs one factorial job on the memory-mapped core: clear, load operand,
// set interrupt enable, start, wait for done, read result, store it to
// memory, clear, respond.
// Ports: clk, reset_n; cmd_valid/cmd_ready/cmd_operand/cmd_dst_addr job request;
//        m_bus master bus; interrupt core done; rsp_valid/rsp_error/
//        rsp_result_h/rsp_result_l job response.
// Build option: FACT_IRQ_WAIT_EN -- wait on the interrupt instead of polling
//        OPDONE, and enable the core interrupt.
module fact_bus_master
  import fact_bus_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR    = 16'h7000,
  parameter logic [31:0] POLL_TIMEOUT = 32'd1000000
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [DATA_W-1:0] cmd_operand,
  input  logic [ADDR_W-1:0] cmd_dst_addr,
  fact_bus_if.master        m_bus,
  input  logic              interrupt,
  output logic              rsp_valid,
  output logic              rsp_error,
  output logic [DATA_W-1:0] rsp_result_h,
  output logic [DATA_W-1:0] rsp_result_l
);

  localparam logic [ADDR_W-1:0] A_OPSTART  = ADDR_W'(BASE_ADDR + OFF_OPSTART);
  localparam logic [ADDR_W-1:0] A_OPCLEAR  = ADDR_W'(BASE_ADDR + OFF_OPCLEAR);
  localparam logic [ADDR_W-1:0] A_OPDONE   = ADDR_W'(BASE_ADDR + OFF_OPDONE);
  localparam logic [ADDR_W-1:0] A_INTR_EN  = ADDR_W'(BASE_ADDR + OFF_INTR_EN);
  localparam logic [ADDR_W-1:0] A_OPERAND  = ADDR_W'(BASE_ADDR + OFF_OPERAND);
  localparam logic [ADDR_W-1:0] A_RESULT_H = ADDR_W'(BASE_ADDR + OFF_RESULT_H);
  localparam logic [ADDR_W-1:0] A_RESULT_L = ADDR_W'(BASE_ADDR + OFF_RESULT_L);
`ifdef FACT_IRQ_WAIT_EN
  localparam logic [DATA_W-1:0] IE_VAL = 64'd1;
`else
  localparam logic [DATA_W-1:0] IE_VAL = 64'd0;
`endif

  state_e            state_q, state_d;
  logic [DATA_W-1:0] opnd_q, opnd_d;
  logic [ADDR_W-1:0] dst_q, dst_d;
  logic [DATA_W-1:0] res_h_q, res_h_d, res_l_q, res_l_d;
  logic              err_q, err_d;
  logic [31:0]       cnt_q, cnt_d;
  logic              cmd_ready_q, rsp_valid_q, rsp_error_q;
  logic              timeout_c;
  bus_op_t           op_c;
  logic              done_c, rvalid_c;
  logic [DATA_W-1:0] rdata_c;

`ifndef FACT_IRQ_WAIT_EN
  logic unused_irq;
  assign unused_irq = interrupt;
`endif

  fact_bus_xfer u_xfer (
    .clk      (clk),
    .reset_n  (reset_n),
    .op_i     (op_c),
    .bus      (m_bus),
    .done_c   (done_c),
    .rvalid_c (rvalid_c),
    .rdata_c  (rdata_c)
  );

  assign timeout_c = (cnt_q >= POLL_TIMEOUT);

  // Next-state and job data
  always_comb begin
    state_d = state_q;
    opnd_d  = opnd_q;
    dst_d   = dst_q;
    res_h_d = res_h_q;
    res_l_d = res_l_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: if (cmd_valid) begin
        state_d = ST_CLR1;
        opnd_d  = cmd_operand;
        dst_d   = cmd_dst_addr;
        err_d   = 1'b0;
      end
      ST_CLR1:    if (done_c) state_d = ST_CLR0;
      ST_CLR0:    if (done_c) state_d = ST_WR_OPND;
      ST_WR_OPND: if (done_c) state_d = ST_WR_IE;
      ST_WR_IE:   if (done_c) state_d = ST_WR_GO;
      ST_WR_GO: if (done_c) begin
        state_d = ST_WAIT;
        cnt_d   = '0;
      end
`ifdef FACT_IRQ_WAIT_EN
      ST_WAIT: begin
        cnt_d = cnt_q + 32'd1;
        if (interrupt) begin
          state_d = ST_RD_H;
        end else if (timeout_c) begin
          state_d = ST_END1;
          err_d   = 1'b1;
        end
      end
      ST_WAIT_CAP: state_d = ST_WAIT;
`else
      ST_WAIT: begin
        cnt_d = cnt_q + 32'd1;
        if (done_c) state_d = ST_WAIT_CAP;
      end
      // Timeout is only taken between polls so a pending read is never cut short
      ST_WAIT_CAP: begin
        cnt_d = cnt_q + 32'd1;
        if (rvalid_c) begin
          if (rdata_c[0]) begin
            state_d = ST_RD_H;
          end else if (timeout_c) begin
            state_d = ST_END1;
            err_d   = 1'b1;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
`endif
      ST_RD_H: if (done_c) state_d = ST_CAP_H;
      ST_CAP_H: if (rvalid_c) begin
        res_h_d = rdata_c;
        state_d = ST_RD_L;
      end
      ST_RD_L: if (done_c) state_d = ST_CAP_L;
      ST_CAP_L: if (rvalid_c) begin
        res_l_d = rdata_c;
        state_d = ST_ST_L;
      end
      ST_ST_L: if (done_c) state_d = ST_ST_H;
      ST_ST_H: if (done_c) state_d = ST_END1;
      ST_END1: if (done_c) state_d = ST_END0;
      ST_END0: if (done_c) state_d = ST_RESP;
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Op for the state being entered; uses _d data so stores see fresh captures
  always_comb begin
    op_c = '0;
    case (state_d)
      ST_CLR1, ST_END1: op_c = mk_op(1'b1, A_OPCLEAR, 64'd1);
      ST_CLR0, ST_END0: op_c = mk_op(1'b1, A_OPCLEAR, 64'd0);
      ST_WR_OPND:       op_c = mk_op(1'b1, A_OPERAND, opnd_d);
      ST_WR_IE:         op_c = mk_op(1'b1, A_INTR_EN, IE_VAL);
      ST_WR_GO:         op_c = mk_op(1'b1, A_OPSTART, 64'd1);
`ifndef FACT_IRQ_WAIT_EN
      ST_WAIT:          op_c = mk_op(1'b0, A_OPDONE, 64'd0);
`endif
      ST_RD_H:          op_c = mk_op(1'b0, A_RESULT_H, 64'd0);
      ST_RD_L:          op_c = mk_op(1'b0, A_RESULT_L, 64'd0);
      ST_ST_L:          op_c = mk_op(1'b1, dst_d, res_l_d);
      ST_ST_H:          op_c = mk_op(1'b1, ADDR_W'(dst_d + 16'd1), res_h_d);
      default:          op_c = '0;
    endcase
  end

  // State, job data and registered handshake outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      opnd_q      <= '0;
      dst_q       <= '0;
      res_h_q     <= '0;
      res_l_q     <= '0;
      err_q       <= 1'b0;
      cnt_q       <= '0;
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      opnd_q      <= opnd_d;
      dst_q       <= dst_d;
      res_h_q     <= res_h_d;
      res_l_q     <= res_l_d;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
      cmd_ready_q <= (state_d == ST_IDLE);
      rsp_valid_q <= (state_d == ST_RESP);
      rsp_error_q <= (state_d == ST_RESP) & err_d;
    end
  end

  assign cmd_ready    = cmd_ready_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_error    = rsp_error_q;
  assign rsp_result_h = res_h_q;
  assign rsp_result_l = res_l_q;

endmodule
